spi_ram_arbiter: RTL and testbench
==================================

// Module: spi_ram_arbiter
// PURPOSE
//  Two-port arbiter sharing the single MappedSPIRAM word interface between two requesters:
//  m0 = FemtoRV32 CPU data/instr port, m1 = secondary master (UART loader / DMA).
//  Each port accepts a one-cycle rd or wr strobe, latches the request, holds busy until done.
//  Issues requests downstream one at a time; RAM-side rbusy/wbusy drive completion.
// PARAMETERS
//  AW         20    word-address width (matches mem_address[21:2])
//  FIXED_PRIO 0     0 = round-robin between m0/m1; 1 = m0 always wins when both pending
//  TIMEOUT    1023  max WAIT cycles before abort; 0 disables timeout
// PORTS
//  clk          in   1    system clock
//  reset        in   1    synchronous, active-high reset
//  m0_addr      in   AW   m0 word address, sampled on strobe
//  m0_wdata     in   32   m0 write data, sampled on strobe
//  m0_rd        in   1    m0 read strobe (1-cycle pulse)
//  m0_wr        in   1    m0 write strobe (1-cycle pulse)
//  m0_rdata     out  32   m0 read data, valid when m0_rbusy falls
//  m0_rbusy     out  1    m0 read pending
//  m0_wbusy     out  1    m0 write pending
//  m1_*         --   --   identical set for requester 1 (addr, wdata, rd, wr, rdata, rbusy, wbusy)
//  ram_addr     out  AW   to MappedSPIRAM word_address
//  ram_wdata    out  32   to MappedSPIRAM wdata
//  ram_rd       out  1    1-cycle read strobe to RAM controller
//  ram_wr       out  1    1-cycle write strobe to RAM controller
//  ram_rdata    in   32   from RAM controller
//  ram_rbusy    in   1    from RAM controller
//  ram_wbusy    in   1    from RAM controller
//  grant        out  2    one-hot owner of RAM (debug/status); 00 when idle
//  err_timeout  out  1    sticky: a WAIT exceeded TIMEOUT; cleared only by reset
// BEHAVIOUR
//  Reset: FSM=IDLE; pend[1:0]=0; all outputs 0 (rdata=0, busy=0, ram_rd/wr=0, grant=0); last=m1.
//  Capture: strobe on port N latches addr, wdata, op into slot N; pend[N]=1 on that edge.
//   rd&wr same cycle -> write, read dropped. Strobe while pend[N]=1 ignored (protocol error).
//   Clear of pend[N] and new strobe on the same edge -> new request wins (pend stays 1).
//  Busy: mN_rbusy = pend[N]&op==RD, mN_wbusy = pend[N]&op==WR, registered; high the cycle after strobe.
//  FSM IDLE: if pend!=0 pick slot: only one pending -> it; both -> FIXED_PRIO?m0:(!last);
//   load ram_addr/ram_wdata from slot, grant=onehot(slot), -> ISSUE.
//  ISSUE (1 cycle): ram_rd or ram_wr=1 per op; timeout counter=0; -> WAIT.
//  WAIT: while ram_rbusy|ram_wbusy count++; when both low -> DONE edge:
//   read: mN_rdata<=ram_rdata; pend[N]<=0; last<=N; grant<=0; -> IDLE.
//   TIMEOUT!=0 and count==TIMEOUT -> abort: pend[N]<=0, read returns 32'hFFFF_FFFF,
//   err_timeout<=1, -> IDLE.
//  Latency (no contention, strobe at T): busy high T+1; ram_rd at T+2; RAM busy from T+3;
//   done edge at first low-busy WAIT cycle D; mN_rbusy low, rdata valid at D+1.
//  Non-granted port keeps its pend/busy high throughout; no preemption once ISSUE entered.
//  rdata of port N holds last value until next completed read on N; never touched by other port.
//  Reset mid-operation: aborts in-flight request silently; RAM controller shares reset.
// TESTING
//  m0_rd addr=0x00010 alone, RAM model 8-cycle busy, data 0xDEADBEEF -> ram_rd at T+2,
//   m0_rbusy high T+1..done, m0_rdata=0xDEADBEEF; m1 busy never asserted.
//  m0_rd and m1_wr(addr 0x00020, 0x12345678) same cycle, RR, last=m1 -> m0 served first,
//   then ram_wr with 0x12345678 @0x00020; grant 01 then 10; next tie goes to m1.
//  FIXED_PRIO=1, m0 re-strobes immediately after each completion, m1 pending -> m1 starves,
//   m0 always granted; same with FIXED_PRIO=0 -> strict alternation m0,m1,m0,...
//  m1_rd and m1_wr both high one cycle -> single ram_wr issued, m1_wbusy only, rbusy stays 0.
//  TIMEOUT=16, RAM model holds rbusy forever -> abort after 16 WAIT cycles, m0_rdata=0xFFFFFFFF,
//   err_timeout=1 sticky, next request still serviced normally.
//  Reset asserted during WAIT -> next cycle FSM IDLE, pend=0, all busy/grant/err 0.

Source files
------------

// File: rtl/spi_ram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_ram_arbiter
// Description : Two-requester arbiter in front of the MappedSPIRAM word
//               interface. Each port latches a one-cycle rd/wr strobe into a
//               slot, holds busy until the RAM transaction finishes, and the
//               FSM serves one slot at a time (round-robin or fixed priority)
//               with an optional WAIT-phase timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_ram_arbiter #(
    parameter int AW         = 20,
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = 1023
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    input  logic          m0_rd,
    input  logic          m0_wr,
    output logic [31:0]   m0_rdata,
    output logic          m0_rbusy,
    output logic          m0_wbusy,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    input  logic          m1_rd,
    input  logic          m1_wr,
    output logic [31:0]   m1_rdata,
    output logic          m1_rbusy,
    output logic          m1_wbusy,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    output logic          ram_rd,
    output logic          ram_wr,
    input  logic [31:0]   ram_rdata,
    input  logic          ram_rbusy,
    input  logic          ram_wbusy,
    output logic [1:0]    grant,
    output logic          err_timeout
);

    // Timeout counter is sized to hold TIMEOUT; a 1-bit dummy when disabled.
    localparam int              c_CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CW-1:0] c_TO = c_CW'(TIMEOUT);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;

    // Per-port request slots (index 0 = m0, 1 = m1); r_op = 1 means write.
    logic [AW-1:0]   r_addr  [2];
    logic [31:0]     r_wdata [2];
    logic [31:0]     r_rdata [2];
    logic [1:0]      r_op;
    logic [1:0]      r_pend;

    logic [1:0]      r_state;
    logic            r_sel;
    logic            r_cur_op;
    logic            r_last;
    logic [1:0]      r_grant;
    logic [AW-1:0]   r_ram_addr;
    logic [31:0]     r_ram_wdata;
    logic            r_ram_rd;
    logic            r_ram_wr;
    logic [c_CW-1:0] r_cnt;
    logic            r_err;

    logic [AW-1:0]   w_addr_in  [2];
    logic [31:0]     w_wdata_in [2];
    logic [1:0]      w_rd_in;
    logic [1:0]      w_wr_in;
    logic            w_ram_busy;
    logic            w_done;
    logic            w_abort;
    logic [1:0]      w_clr;
    logic [1:0]      w_acc;
    logic            w_pick;

    assign w_addr_in[0]  = m0_addr;
    assign w_addr_in[1]  = m1_addr;
    assign w_wdata_in[0] = m0_wdata;
    assign w_wdata_in[1] = m1_wdata;
    assign w_rd_in       = {m1_rd, m0_rd};
    assign w_wr_in       = {m1_wr, m0_wr};

    assign w_ram_busy = ram_rbusy | ram_wbusy;
    assign w_done     = (r_state == c_WAIT) && !w_ram_busy;
    assign w_abort    = (TIMEOUT != 0) && (r_state == c_WAIT) && w_ram_busy && (r_cnt == c_TO);
    assign w_clr      = (w_done || w_abort) ? (r_sel ? 2'b10 : 2'b01) : 2'b00;

    // A strobe is accepted when the slot is free or is being released this edge.
    assign w_acc = (w_rd_in | w_wr_in) & (~r_pend | w_clr);

    // Slot selection: a lone pending slot wins, a tie goes by priority mode.
    always_comb begin
        w_pick = 1'b0;
        if (r_pend == 2'b10) begin
            w_pick = 1'b1;
        end else if (r_pend == 2'b11) begin
            w_pick = (FIXED_PRIO != 0) ? 1'b0 : ~r_last;
        end
    end

    // Request capture per port; a write strobe overrides a simultaneous read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= 2'b00;
            r_op   <= 2'b00;
            for (int n = 0; n < 2; n++) begin
                r_addr[n]  <= '0;
                r_wdata[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (w_acc[n]) begin
                    r_addr[n]  <= w_addr_in[n];
                    r_wdata[n] <= w_wdata_in[n];
                    r_op[n]    <= w_wr_in[n];
                    r_pend[n]  <= 1'b1;
                end else if (w_clr[n]) begin
                    r_pend[n]  <= 1'b0;
                end
            end
        end
    end

    // Downstream sequencer: IDLE picks a slot, ISSUE strobes the RAM, WAIT
    // tracks RAM busy and retires (or aborts) the granted request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_sel       <= 1'b0;
            r_cur_op    <= 1'b0;
            r_last      <= 1'b1;
            r_grant     <= 2'b00;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_ram_rd    <= 1'b0;
            r_ram_wr    <= 1'b0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_rdata[0]  <= '0;
            r_rdata[1]  <= '0;
        end else begin
            r_ram_rd <= 1'b0;
            r_ram_wr <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (r_pend != 2'b00) begin
                        r_sel       <= w_pick;
                        r_cur_op    <= r_op[w_pick];
                        r_ram_addr  <= r_addr[w_pick];
                        r_ram_wdata <= r_wdata[w_pick];
                        r_grant     <= w_pick ? 2'b10 : 2'b01;
                        r_ram_rd    <= ~r_op[w_pick];
                        r_ram_wr    <= r_op[w_pick];
                        r_state     <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= c_WAIT;
                end
                c_WAIT: begin
                    if (w_done) begin
                        if (!r_cur_op) begin
                            r_rdata[r_sel] <= ram_rdata;
                        end
                        r_last  <= r_sel;
                        r_grant <= 2'b00;
                        r_state <= c_IDLE;
                    end else if (w_abort) begin
                        if (!r_cur_op) begin
                            r_rdata[r_sel] <= 32'hFFFF_FFFF;
                        end
                        r_err   <= 1'b1;
                        r_last  <= r_sel;
                        r_grant <= 2'b00;
                        r_state <= c_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign m0_rdata    = r_rdata[0];
    assign m1_rdata    = r_rdata[1];
    assign m0_rbusy    = r_pend[0] & ~r_op[0];
    assign m0_wbusy    = r_pend[0] &  r_op[0];
    assign m1_rbusy    = r_pend[1] & ~r_op[1];
    assign m1_wbusy    = r_pend[1] &  r_op[1];
    assign ram_addr    = r_ram_addr;
    assign ram_wdata   = r_ram_wdata;
    assign ram_rd      = r_ram_rd;
    assign ram_wr      = r_ram_wr;
    assign grant       = r_grant;
    assign err_timeout = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_spi_ram_arbiter
// Description : Directed bench for spi_ram_arbiter. Instance 0 is round-robin,
//               instance 1 fixed priority, both with TIMEOUT=16, each behind a
//               small busy-counting RAM model. Expected RAM transactions are
//               queued when requests are driven and popped as the RAM sees them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_ram_arbiter;

    localparam int AW = 20;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] m0_addr [2];
    logic [AW-1:0] m1_addr [2];
    logic [31:0]   m0_wdata [2];
    logic [31:0]   m1_wdata [2];
    logic [1:0]    m0_rd, m0_wr, m1_rd, m1_wr;
    logic [31:0]   m0_rdata [2];
    logic [31:0]   m1_rdata [2];
    logic [1:0]    m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy;
    logic [AW-1:0] ram_addr [2];
    logic [31:0]   ram_wdata [2];
    logic [31:0]   ram_rdata [2];
    logic [1:0]    ram_rd, ram_wr, ram_rbusy, ram_wbusy, err;
    logic [1:0]    grant [2];

    int busy_len = 8;
    bit hang     = 1'b0;
    int checks   = 0;
    int errors   = 0;

    typedef struct packed {
        logic          d;
        logic [1:0]    grant;
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
    } txn_t;

    txn_t exp_q[$];

    function automatic logic [31:0] ram_data(input logic [AW-1:0] a);
        return (a == 20'h00010) ? 32'hDEAD_BEEF : {12'hA5C, a};
    endfunction

    generate
        for (genvar d = 0; d < 2; d++) begin : g_dut
            logic        rb, wb;
            int          cnt;
            logic [31:0] rdq;

            spi_ram_arbiter #(.AW(AW), .FIXED_PRIO(d), .TIMEOUT(16)) dut (
                .clk(clk), .reset(reset),
                .m0_addr(m0_addr[d]), .m0_wdata(m0_wdata[d]), .m0_rd(m0_rd[d]), .m0_wr(m0_wr[d]),
                .m0_rdata(m0_rdata[d]), .m0_rbusy(m0_rbusy[d]), .m0_wbusy(m0_wbusy[d]),
                .m1_addr(m1_addr[d]), .m1_wdata(m1_wdata[d]), .m1_rd(m1_rd[d]), .m1_wr(m1_wr[d]),
                .m1_rdata(m1_rdata[d]), .m1_rbusy(m1_rbusy[d]), .m1_wbusy(m1_wbusy[d]),
                .ram_addr(ram_addr[d]), .ram_wdata(ram_wdata[d]), .ram_rd(ram_rd[d]), .ram_wr(ram_wr[d]),
                .ram_rdata(ram_rdata[d]), .ram_rbusy(ram_rbusy[d]), .ram_wbusy(ram_wbusy[d]),
                .grant(grant[d]), .err_timeout(err[d])
            );

            // RAM model: busy for busy_len cycles after a strobe, frozen while hang is set.
            always @(posedge clk) begin
                if (reset) begin
                    rb <= 1'b0; wb <= 1'b0; cnt <= 0; rdq <= '0;
                end else if (ram_rd[d]) begin
                    rb <= 1'b1; cnt <= busy_len; rdq <= ram_data(ram_addr[d]);
                end else if (ram_wr[d]) begin
                    wb <= 1'b1; cnt <= busy_len;
                end else if (cnt > 0 && !hang) begin
                    cnt <= cnt - 1;
                    if (cnt == 1) begin
                        rb <= 1'b0; wb <= 1'b0;
                    end
                end
            end

            assign ram_rbusy[d] = rb;
            assign ram_wbusy[d] = wb;
            assign ram_rdata[d] = rdq;
        end
    endgenerate

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_txn(input int d, input int port, input logic we,
                              input logic [AW-1:0] a, input logic [31:0] wd);
        txn_t t;
        t.d     = d[0];
        t.grant = (port != 0) ? 2'b10 : 2'b01;
        t.we    = we;
        t.addr  = a;
        t.wdata = we ? wd : 32'h0;
        exp_q.push_back(t);
    endtask

    // Pops one expected transaction for every RAM strobe seen on either instance.
    task automatic monitor();
        txn_t o, e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!reset && (ram_rd[d] || ram_wr[d])) begin
                    o.d     = d[0];
                    o.grant = grant[d];
                    o.we    = ram_wr[d];
                    o.addr  = ram_addr[d];
                    o.wdata = ram_wr[d] ? ram_wdata[d] : 32'h0;
                    if (exp_q.size() == 0) e = ~o;
                    else                   e = exp_q.pop_front();
                    chk("ram_txn", 64'(o), 64'(e));
                    chk("ram_rd_wr_excl", 64'(ram_rd[d] & ram_wr[d]), 64'h0);
                end
            end
        end
    endtask

    task automatic check_idle(input int d, input string tag);
        chk({tag, "_status"}, 64'({m0_rbusy[d], m0_wbusy[d], m1_rbusy[d], m1_wbusy[d],
                                   grant[d], err[d], ram_rd[d], ram_wr[d]}), 64'h0);
        chk({tag, "_rdata"}, {m0_rdata[d], m1_rdata[d]}, 64'h0);
    endtask

    // Waits for the given port's busy to drop; seen ORs {m0_rb,m0_wb,m1_rb,m1_wb}.
    task automatic wait_low(input int d, input int port, output int n, output logic [3:0] seen);
        n    = 0;
        seen = 4'b0000;
        while (((port != 0) ? (m1_rbusy[d] | m1_wbusy[d]) : (m0_rbusy[d] | m0_wbusy[d])) && n < 100) begin
            seen = seen | {m0_rbusy[d], m0_wbusy[d], m1_rbusy[d], m1_wbusy[d]};
            cyc();
            n++;
        end
    endtask

    function automatic int exp_port(input int d, input int k);
        return (d != 0) ? 0 : (k % 2);
    endfunction

    function automatic logic [AW-1:0] starve_addr(input int p);
        return (p != 0) ? 20'h00050 : 20'h00040;
    endfunction

    // Both ports keep re-requesting the moment they complete.
    task automatic starve(input int d, input int nsvc);
        int   n, p;
        logic found;
        m0_rd[d] = 1'b1; m0_addr[d] = starve_addr(0);
        m1_rd[d] = 1'b1; m1_addr[d] = starve_addr(1);
        expect_txn(d, exp_port(d, 0), 1'b0, starve_addr(exp_port(d, 0)), 32'h0);
        cyc();
        m0_rd[d] = 1'b0; m1_rd[d] = 1'b0;
        for (int k = 0; k < nsvc; k++) begin
            found = 1'b0;
            n     = 0;
            while (!found && n < 100) begin
                cyc();
                n++;
                if (grant[d] != 2'b00 && !ram_rd[d] && !ram_wr[d] && !ram_rbusy[d] && !ram_wbusy[d])
                    found = 1'b1;
            end
            chk($sformatf("starve%0d_done%0d", d, k), 64'(found), 64'h1);
            p = exp_port(d, k);
            chk($sformatf("starve%0d_grant%0d", d, k), 64'(grant[d]), (p != 0) ? 64'h2 : 64'h1);
            if (k < nsvc - 1) begin
                if (p != 0) m1_rd[d] = 1'b1;
                else        m0_rd[d] = 1'b1;
                expect_txn(d, exp_port(d, k + 1), 1'b0, starve_addr(exp_port(d, k + 1)), 32'h0);
                cyc();
                m0_rd[d] = 1'b0; m1_rd[d] = 1'b0;
            end
        end
        p = (d != 0) ? 1 : exp_port(d, nsvc);
        expect_txn(d, p, 1'b0, starve_addr(p), 32'h0);
    endtask

    initial begin
        int         n;
        logic [3:0] seen;
        logic       found;

        for (int d = 0; d < 2; d++) begin
            m0_addr[d] = '0; m1_addr[d] = '0; m0_wdata[d] = '0; m1_wdata[d] = '0;
        end
        m0_rd = '0; m0_wr = '0; m1_rd = '0; m1_wr = '0;
        fork
            monitor();
        join_none

        cyc(3);
        reset = 1'b0;
        for (int d = 0; d < 2; d++) check_idle(d, $sformatf("reset%0d", d));

        // Tie after reset (last = m1): m0 read first, then m1 write.
        m0_rd[0] = 1'b1; m0_addr[0] = 20'h00030;
        m1_wr[0] = 1'b1; m1_addr[0] = 20'h00020; m1_wdata[0] = 32'h1234_5678;
        expect_txn(0, 0, 1'b0, 20'h00030, 32'h0);
        expect_txn(0, 1, 1'b1, 20'h00020, 32'h1234_5678);
        cyc();
        m0_rd[0] = 1'b0; m1_wr[0] = 1'b0;
        chk("tieA_busy", 64'({m0_rbusy[0], m0_wbusy[0], m1_rbusy[0], m1_wbusy[0]}), 64'h9);
        cyc();
        chk("tieA_grant_m0", 64'(grant[0]), 64'h1);
        wait_low(0, 0, n, seen);
        chk("tieA_m0_rdata", 64'(m0_rdata[0]), 64'hA5C0_0030);
        chk("tieA_m1_still_busy", 64'(m1_wbusy[0]), 64'h1);
        n = 0;
        while (grant[0] != 2'b10 && n < 10) begin cyc(); n++; end
        chk("tieA_grant_m1", 64'(grant[0]), 64'h2);
        wait_low(0, 1, n, seen);
        chk("tieA_m1_done", 64'(m1_wbusy[0]), 64'h0);
        chk("tieA_m1_rdata_untouched", 64'(m1_rdata[0]), 64'h0);

        // Lone m0 read with latency check and an ignored re-strobe while pending.
        m0_rd[0] = 1'b1; m0_addr[0] = 20'h00010;
        expect_txn(0, 0, 1'b0, 20'h00010, 32'h0);
        cyc();
        m0_rd[0] = 1'b0;
        chk("solo_busy_t1", 64'({m0_rbusy[0], m0_wbusy[0]}), 64'h2);
        cyc();
        chk("solo_ram_rd_t2", 64'({ram_rd[0], grant[0]}), 64'h5);
        m0_wr[0] = 1'b1; m0_addr[0] = 20'h00099; m0_wdata[0] = 32'h5555_AAAA;
        cyc();
        m0_wr[0] = 1'b0;
        wait_low(0, 0, n, seen);
        chk("solo_latency", 64'(n), 64'd9);
        chk("solo_busy_seen", 64'(seen), 64'h8);
        chk("solo_rdata", 64'(m0_rdata[0]), 64'hDEAD_BEEF);
        cyc(3);

        // Tie with last = m0: m1 served first.
        m0_rd[0] = 1'b1; m0_addr[0] = 20'h00031;
        m1_rd[0] = 1'b1; m1_addr[0] = 20'h00041;
        expect_txn(0, 1, 1'b0, 20'h00041, 32'h0);
        expect_txn(0, 0, 1'b0, 20'h00031, 32'h0);
        cyc();
        m0_rd[0] = 1'b0; m1_rd[0] = 1'b0;
        cyc();
        chk("tieB_grant_m1", 64'(grant[0]), 64'h2);
        wait_low(0, 1, n, seen);
        chk("tieB_m1_rdata", 64'(m1_rdata[0]), 64'hA5C0_0041);
        wait_low(0, 0, n, seen);
        chk("tieB_m0_rdata", 64'(m0_rdata[0]), 64'hA5C0_0031);

        // rd and wr together on m1: a single write.
        m1_rd[0] = 1'b1; m1_wr[0] = 1'b1; m1_addr[0] = 20'h00022; m1_wdata[0] = 32'hCAFE_F00D;
        expect_txn(0, 1, 1'b1, 20'h00022, 32'hCAFE_F00D);
        cyc();
        m1_rd[0] = 1'b0; m1_wr[0] = 1'b0;
        wait_low(0, 1, n, seen);
        chk("rdwr_busy_seen", 64'(seen), 64'h1);
        chk("rdwr_m1_rdata_kept", 64'(m1_rdata[0]), 64'hA5C0_0041);

        // Timeout abort with a RAM that never releases busy.
        hang = 1'b1;
        m0_rd[0] = 1'b1; m0_addr[0] = 20'h00060;
        expect_txn(0, 0, 1'b0, 20'h00060, 32'h0);
        cyc();
        m0_rd[0] = 1'b0;
        cyc();
        wait_low(0, 0, n, seen);
        chk("to_cycles", 64'(n), 64'd18);
        chk("to_rdata", 64'(m0_rdata[0]), 64'hFFFF_FFFF);
        chk("to_err", 64'({err[0], grant[0]}), 64'h4);
        hang = 1'b0;
        cyc(12);
        m1_rd[0] = 1'b1; m1_addr[0] = 20'h00070;
        expect_txn(0, 1, 1'b0, 20'h00070, 32'h0);
        cyc();
        m1_rd[0] = 1'b0;
        wait_low(0, 1, n, seen);
        chk("to_next_rdata", 64'(m1_rdata[0]), 64'hA5C0_0070);
        chk("to_err_sticky", 64'(err[0]), 64'h1);
        chk("to_m0_rdata_kept", 64'(m0_rdata[0]), 64'hFFFF_FFFF);

        // Reset clears everything, including the sticky error.
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        check_idle(0, "rst2");

        // Fixed priority: m1 starves while m0 keeps requesting.
        starve(1, 4);
        chk("fp_m1_starved", 64'(m1_rbusy[1]), 64'h1);
        wait_low(1, 1, n, seen);
        chk("fp_m1_finally", 64'({m1_rbusy[1], m1_rdata[1]}), 64'h0_A5C0_0050);

        // Round-robin: strict alternation, then reset while the leftover is in WAIT.
        starve(0, 4);
        found = 1'b0;
        n     = 0;
        while (!found && n < 50) begin
            cyc();
            n++;
            if (grant[0] != 2'b00 && ram_rbusy[0]) found = 1'b1;
        end
        chk("midrst_in_wait", 64'(found), 64'h1);
        reset = 1'b1;
        cyc();
        check_idle(0, "midrst");
        reset = 1'b0;
        cyc(3);
        chk("midrst_no_restart", 64'({grant[0], ram_rd[0], ram_wr[0]}), 64'h0);
        chk("sb_empty", 64'(exp_q.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
